// File: rtl/wqe_rd_responder_if.sv
// wqe_rd_responder_if: AXI4 read-channel bundle between the WQE-fetch master and the responder
interface wqe_rd_responder_if #(
  parameter int AW = 32,
  parameter int DW = 512
);
  logic          arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic          rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/wqe_rd_responder.sv
// wqe_rd_responder: serves AXI4 INCR read bursts from an internal WQE RAM through a 2-entry skid buffer.
// Define WQE_RD_ERR_CHK_EN to answer non-INCR or non-64-byte bursts with SLVERR.
module wqe_rd_responder #(
  parameter int DDR_C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 512,
  parameter int WQE_DEPTH = 256,
  parameter logic [DDR_C_AXI_ADDR_WIDTH-1:0] WQE_BASE_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          rstn,
  wqe_rd_responder_if.slave             s_axi,
  input  logic                          wqe_wr_en,
  input  logic [$clog2(WQE_DEPTH)-1:0]  wqe_wr_idx,
  input  logic [C_AXI_DATA_WIDTH-1:0]   wqe_wr_data,
  output logic [31:0]                   rd_burst_cnt
);
  localparam int AW = DDR_C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int RW = $clog2(WQE_DEPTH);
  localparam int IW = AW - 5;
  typedef enum logic [1:0] {IDLE, RD, LAST} state_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;
  logic [DW-1:0] mem [WQE_DEPTH];
  state_t        state_q;
  logic          arready_q, arid_q, below_q, bad_q;
  logic [IW-1:0] idx_q;
  logic [8:0]    iss_left_q, acc_left_q;
  logic          v1_q, last1_q;
  logic [1:0]    resp1_q;
  logic [DW-1:0] ram_q;
  beat_t         sk_q [2];
  logic [1:0]    sk_cnt_q;
  beat_t         out_q;
  logic          rvalid_q, rid_q;
  logic [31:0]   cnt_q;
  logic [AW-1:0] off;
  logic          ar_hs, pop, issue, oor, load, sk_pop, sk_push, ar_bad;
  logic [2:0]    occ;
  logic [1:0]    issue_resp, cnt_after_pop;
  beat_t         b1, src;
  logic          unused_bits;
`ifdef WQE_RD_ERR_CHK_EN
  assign ar_bad = s_axi.arburst != 2'b01 || s_axi.arsize != 3'b110;
  assign unused_bits = ^off[5:0];
`else
  assign ar_bad = 1'b0;
  assign unused_bits = ^{off[5:0], s_axi.arburst, s_axi.arsize};
`endif
  assign off = s_axi.araddr - WQE_BASE_ADDR;
  assign ar_hs = s_axi.arvalid & arready_q;
  assign pop = rvalid_q & s_axi.rready;
  // Credit check: RAM stage + skid + output register never hold more than 3 beats
  assign occ = 3'(v1_q) + 3'(sk_cnt_q) + 3'(rvalid_q);
  assign issue = iss_left_q != 9'd0 && (occ - 3'(pop)) < 3'd3;
  assign oor = idx_q >= IW'(WQE_DEPTH);
  assign issue_resp = bad_q ? 2'b10 : (below_q || oor) ? 2'b11 : 2'b00;
  assign b1 = '{data: resp1_q == 2'b00 ? ram_q : '0, resp: resp1_q, last: last1_q};
  assign load = !rvalid_q || pop;
  assign src = sk_cnt_q != 2'd0 ? sk_q[0] : b1;
  assign sk_pop = load && sk_cnt_q != 2'd0;
  assign sk_push = v1_q && !(load && sk_cnt_q == 2'd0);
  assign cnt_after_pop = sk_cnt_q - 2'(sk_pop);
  // RAM and skid payload carry no reset; RAM reads are read-first on collisions
  always_ff @(posedge clk) begin
    if (wqe_wr_en) mem[wqe_wr_idx] <= wqe_wr_data;
    if (issue) ram_q <= mem[idx_q[RW-1:0]];
    if (sk_pop) sk_q[0] <= sk_q[1];
    if (sk_push) sk_q[cnt_after_pop[0]] <= b1;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      arready_q  <= 1'b0;
      arid_q     <= 1'b0;
      below_q    <= 1'b0;
      bad_q      <= 1'b0;
      idx_q      <= '0;
      iss_left_q <= '0;
      acc_left_q <= '0;
      v1_q       <= 1'b0;
      resp1_q    <= 2'b00;
      last1_q    <= 1'b0;
      sk_cnt_q   <= 2'd0;
      out_q      <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (issue) begin
        idx_q      <= idx_q + IW'(1);
        iss_left_q <= iss_left_q - 9'd1;
      end
      v1_q     <= issue;
      resp1_q  <= issue_resp;
      last1_q  <= iss_left_q == 9'd1;
      sk_cnt_q <= cnt_after_pop + 2'(sk_push);
      if (load) begin
        rvalid_q <= sk_cnt_q != 2'd0 || v1_q;
        if (sk_cnt_q != 2'd0 || v1_q) begin
          out_q <= src;
          rid_q <= arid_q;
        end
      end
      case (state_q)
        IDLE: begin
          arready_q <= !ar_hs;
          if (ar_hs) begin
            arid_q     <= s_axi.arid;
            below_q    <= s_axi.araddr < WQE_BASE_ADDR;
            bad_q      <= ar_bad;
            idx_q      <= {1'b0, off[AW-1:6]};
            iss_left_q <= 9'(s_axi.arlen) + 9'd1;
            acc_left_q <= 9'(s_axi.arlen) + 9'd1;
            state_q    <= s_axi.arlen == 8'd0 ? LAST : RD;
          end
        end
        RD: if (pop) begin
          acc_left_q <= acc_left_q - 9'd1;
          if (acc_left_q == 9'd2) state_q <= LAST;
        end
        LAST: if (pop && out_q.last) begin
          state_q   <= IDLE;
          arready_q <= 1'b1;
          cnt_q     <= cnt_q + 32'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = out_q.data;
  assign s_axi.rresp   = out_q.resp;
  assign s_axi.rlast   = out_q.last;
  assign s_axi.rid     = rid_q;
  assign rd_burst_cnt  = cnt_q;
endmodule

// File: tb/tb_wqe_rd_responder.sv
// tb_wqe_rd_responder: directed bursts against wqe_rd_responder with hand-computed expectations.
module tb_wqe_rd_responder;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic wqe_wr_en = 1'b0;
  logic [7:0] wqe_wr_idx = '0;
  logic [511:0] wqe_wr_data = '0;
  logic [31:0] rd_burst_cnt;
  int total = 0;
  int bad = 0;
  logic [511:0] gd [16];
  logic [1:0] gr [16];
  logic gl [16];
  logic gi [16];
  int nb;
  wqe_rd_responder_if #(.AW(32), .DW(512)) s_axi ();
  wqe_rd_responder dut (
    .clk(clk), .rstn(rstn), .s_axi(s_axi),
    .wqe_wr_en(wqe_wr_en), .wqe_wr_idx(wqe_wr_idx), .wqe_wr_data(wqe_wr_data),
    .rd_burst_cnt(rd_burst_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic fill(input logic [7:0] idx, input logic [511:0] d);
    @(negedge clk);
    wqe_wr_en = 1'b1;
    wqe_wr_idx = idx;
    wqe_wr_data = d;
    @(negedge clk);
    wqe_wr_en = 1'b0;
  endtask
  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] bt, input logic id);
    int n = 0;
    @(negedge clk);
    s_axi.arid = id;
    s_axi.araddr = addr;
    s_axi.arlen = len;
    s_axi.arsize = 3'b110;
    s_axi.arburst = bt;
    s_axi.arvalid = 1'b1;
    while (!s_axi.arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_wait", n < 20, 1);
    @(posedge clk);
    #1 s_axi.arvalid = 1'b0;
  endtask
  task automatic burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] bt, input logic id,
                       input bit stall, input bit col, input logic [511:0] col_d);
    logic rv1, rv2, done, hv;
    logic [515:0] hold;
    int i;
    ar_issue(addr, len, bt, id);
    if (col) begin
      wqe_wr_en = 1'b1;
      wqe_wr_idx = addr[13:6];
      wqe_wr_data = col_d;
    end
    @(negedge clk);
    rv1 = s_axi.rvalid;
    @(posedge clk);
    #1 wqe_wr_en = 1'b0;
    @(negedge clk);
    rv2 = s_axi.rvalid;
    chk("rv_lat", {rv1, rv2}, 2'b00);
    i = 0;
    done = 1'b0;
    hv = 1'b0;
    hold = '0;
    nb = 0;
    while (!done && i < 200) begin
      @(negedge clk);
      if (i == 0) chk("rv_first", s_axi.rvalid, 1);
      if (hv) chk("stall_hold", s_axi.rvalid && {s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.rid} == hold, 1);
      s_axi.rready = stall ? (i % 4 == 0 || i % 4 == 3) : 1'b1;
      hv = s_axi.rvalid && !s_axi.rready;
      hold = {s_axi.rdata, s_axi.rresp, s_axi.rlast, s_axi.rid};
      if (s_axi.rvalid && s_axi.rready) begin
        if (nb < 16) begin
          gd[nb] = s_axi.rdata;
          gr[nb] = s_axi.rresp;
          gl[nb] = s_axi.rlast;
          gi[nb] = s_axi.rid;
        end
        nb++;
        done = s_axi.rlast;
      end
      i++;
    end
    chk("burst_done", done, 1);
    repeat (3) @(negedge clk);
    chk("no_extra", s_axi.rvalid, 0);
  endtask
  task automatic check_seq(input int n, input logic [7:0] v0, input logic id, input logic [1:0] resp);
    chk("nbeats", nb, n);
    for (int j = 0; j < n && j < 16; j++) begin
      chk($sformatf("data%0d", j), gd[j], resp == 2'b00 ? 512'(v0 + 8'(j)) : '0);
      chk($sformatf("resp%0d", j), gr[j], resp);
      chk($sformatf("last%0d", j), gl[j], j == n - 1);
      chk($sformatf("rid%0d", j), gi[j], id);
    end
  endtask
  initial begin
    int k, n;
    s_axi.arvalid = 1'b0;
    s_axi.arid = 1'b0;
    s_axi.araddr = '0;
    s_axi.arlen = '0;
    s_axi.arsize = '0;
    s_axi.arburst = '0;
    s_axi.rready = 1'b0;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arready", s_axi.arready, 0);
    chk("rst_rvalid", s_axi.rvalid, 0);
    chk("rst_rlast", s_axi.rlast, 0);
    chk("rst_rresp", s_axi.rresp, 0);
    chk("rst_rid", s_axi.rid, 0);
    chk("rst_rdata", s_axi.rdata, 0);
    chk("rst_cnt", rd_burst_cnt, 0);
    rstn = 1'b1;
    #1 chk("arready_pre", s_axi.arready, 0);
    @(negedge clk);
    chk("arready_rise", s_axi.arready, 1);
    for (int j = 0; j < 4; j++) fill(8'(j), 512'(8'hA0 + 8'(j)));
    for (int j = 4; j < 8; j++) fill(8'(j), 512'(8'h50 + 8'(j)));
    fill(8'd255, 512'hFF);
    burst(32'h0, 8'd3, 2'b01, 1'b1, 1'b0, 1'b0, '0);
    check_seq(4, 8'hA0, 1'b1, 2'b00);
    chk("cnt1", rd_burst_cnt, 1);
    burst(32'h0, 8'd3, 2'b01, 1'b1, 1'b1, 1'b0, '0);
    check_seq(4, 8'hA0, 1'b1, 2'b00);
    chk("cnt2", rd_burst_cnt, 2);
    burst(32'h3FC0, 8'd1, 2'b01, 1'b0, 1'b0, 1'b0, '0);
    chk("edge_n", nb, 2);
    chk("edge_d0", gd[0], 512'hFF);
    chk("edge_r0", gr[0], 2'b00);
    chk("edge_l0", gl[0], 0);
    chk("edge_d1", gd[1], 0);
    chk("edge_r1", gr[1], 2'b11);
    chk("edge_l1", gl[1], 1);
    burst(32'h0, 8'd1, 2'b10, 1'b0, 1'b0, 1'b0, '0);
`ifdef WQE_RD_ERR_CHK_EN
    check_seq(2, 8'h00, 1'b0, 2'b10);
`else
    check_seq(2, 8'hA0, 1'b0, 2'b00);
`endif
    burst(32'h4000, 8'd0, 2'b01, 1'b0, 1'b0, 1'b0, '0);
    check_seq(1, 8'h00, 1'b0, 2'b11);
    chk("cnt5", rd_burst_cnt, 5);
    s_axi.rready = 1'b1;
    ar_issue(32'h0, 8'd7, 2'b01, 1'b1);
    k = 0;
    n = 0;
    while (k < 2 && n < 20) begin
      @(negedge clk);
      if (s_axi.rvalid) k++;
      n++;
    end
    chk("mid_beats", k, 2);
    @(posedge clk);
    #1 chk("pre_rst_rv", s_axi.rvalid, 1);
    rstn = 1'b0;
    #1 chk("rst_rv_now", s_axi.rvalid, 0);
    chk("rst_cnt2", rd_burst_cnt, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("arready_rise2", s_axi.arready, 1);
    chk("no_beat_after_rst", s_axi.rvalid, 0);
    burst(32'h80, 8'd0, 2'b01, 1'b0, 1'b0, 1'b0, '0);
    check_seq(1, 8'hA2, 1'b0, 2'b00);
    chk("cnt_after_rst", rd_burst_cnt, 1);
    burst(32'h140, 8'd0, 2'b01, 1'b1, 1'b0, 1'b1, 512'hBB);
    check_seq(1, 8'h55, 1'b1, 2'b00);
    burst(32'h140, 8'd0, 2'b01, 1'b1, 1'b0, 1'b0, '0);
    check_seq(1, 8'hBB, 1'b1, 2'b00);
    chk("cnt3", rd_burst_cnt, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
